result_bcd_convert: RTL



---
 rtl/calc_pkg.sv | 16 +
 rtl/bcd_add3.sv | 13 +
 rtl/result_bcd_convert.sv | 120 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath result stages.
//   RES_W       : default binary result width
//   RES_DIG     : default BCD digit count covering RES_W
//   cvt_state_t : binary-to-BCD converter FSM state encoding
package calc_pkg;

  localparam int RES_W   = 16;
  localparam int RES_DIG = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } cvt_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
//   nib_in  : current BCD digit (0..9)
//   nib_out : corrected digit, ready to be shifted
module bcd_add3 (
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  // The largest input is 9, so 9+3=12 always fits in four bits.
  assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;

endmodule

// File: rtl/result_bcd_convert.sv
// Captures a binary result on the rising edge of the multiply controller's
// done strobe and converts it to packed BCD one bit per clock. The last
// completed conversion is held on digits for the display driver. A one-deep
// pending slot keeps the newest result that arrives while a conversion runs.
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high reset
//   done     : result-ready strobe; only its rising edge starts a capture
//   result   : binary value sampled with the done rising edge
//   digits   : packed BCD, [3:0] = ones, [7:4] = tens, ...
//   busy     : conversion in progress or result pending
//   cvt_done : one-cycle pulse in the cycle digits updates
//
// state  | meaning
// IDLE   | waiting for a done rising edge
// SHIFT  | one add-3 plus left shift per cycle, WIDTH cycles in total
// FINISH | publish digits, then reload from pending slot / new edge or idle
module result_bcd_convert
  import calc_pkg::*;
#(
  parameter int WIDTH = RES_W,
  parameter int NDIG  = RES_DIG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic [WIDTH-1:0]  result,
  output logic [4*NDIG-1:0] digits,
  output logic              busy,
  output logic              cvt_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * NDIG;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  cvt_state_t state;

  logic             done_q;
  logic             rise;
  logic [WIDTH-1:0] bin;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    bcd_adj;
  logic [CW-1:0]    cnt;
  logic             pend_v;
  logic [WIDTH-1:0] pend_val;
  logic [BW+WIDTH-1:0] shifted;

  assign rise = done & ~done_q;

  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_in  (bcd[4*g +: 4]),
      .nib_out (bcd_adj[4*g +: 4])
    );
  end

  // The top nibble's carry-out is discarded by the shift; it is always zero
  // because NDIG digits are enough to hold the largest WIDTH-bit value.
  assign shifted = {bcd_adj, bin} << 1;

  assign busy = (state != IDLE) | pend_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      digits   <= '0;
      pend_v   <= 1'b0;
      pend_val <= '0;
      cvt_done <= 1'b0;
    end else begin
      done_q   <= done;
      cvt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            bin   <= result;
            bcd   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= shifted[BW+WIDTH-1:WIDTH];
          bin <= shifted[WIDTH-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) state <= FINISH;
          // Newest result wins; an older pending value is dropped.
          if (rise) begin
            pend_val <= result;
            pend_v   <= 1'b1;
          end
        end
        FINISH: begin
          digits   <= bcd;
          cvt_done <= 1'b1;
          bcd      <= '0;
          cnt      <= '0;
          if (pend_v) begin
            bin   <= pend_val;
            state <= SHIFT;
            // A simultaneous new edge refills the slot we just drained.
            if (rise) pend_val <= result;
            else      pend_v   <= 1'b0;
          end else if (rise) begin
            bin   <= result;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
